level_clk_sel: RTL and testbench
================================

LEVEL_CLK_SEL -- requirements
Module: level_clk_sel

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 4: number of selectable speed levels, range 2..16.
REQ-002 SHALL have parameter BASE_DIV, default 50000000: level-0 tick period in clock cycles.
REQ-003 SHALL have parameter CNT_W, default 26: counter width, large enough to hold BASE_DIV-1.
REQ-004 SHALL have derived parameter LEVEL_W = max(1, ceil(log2(NUM_LEVELS))).
REQ-005 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1 bit: tick generation enable.
REQ-008 SHALL have port clr, input, 1 bit: synchronous period restart.
REQ-009 SHALL have port level, input, LEVEL_W bits: requested speed level.
REQ-010 SHALL have port CLKHZ, output, 1 bit: registered one-cycle tick pulse.
REQ-011 SHALL have port level_cur, output, LEVEL_W bits: level currently in force.
REQ-012 SHALL have port pend, output, 1 bit: high when the requested level differs from the level in force.

Function
REQ-013 SHALL compute the divisor as DIV(k) = BASE_DIV >> k, clamped to a minimum of 2.
REQ-014 SHALL clamp a level value >= NUM_LEVELS to NUM_LEVELS-1 before any use, including pend and level_cur.
REQ-015 SHALL run internal counter cnt from 0 to DIV(level_cur)-1 and then wrap to 0 while en=1 and clr=0.
REQ-016 SHALL register CLKHZ=1 for exactly one cycle following each cycle in which cnt=DIV(level_cur)-1, en=1 and clr=0, giving a tick period of exactly DIV cycles.
REQ-017 SHALL hold a level change pending until a wrap: when cnt wraps, level_cur SHALL load the clamped level; no other update SHALL occur while en=1 and clr=0, so no period is ever shortened or glitched.
REQ-018 SHALL make the first tick after a wrap-time level change occur exactly DIV(new level) cycles after the previous tick.
REQ-019 SHALL, when en=0, set cnt to 0, load level_cur from the clamped level immediately and hold CLKHZ at 0.
REQ-020 SHALL give clr=1 priority over en and wrap: cnt goes to 0, level_cur loads the clamped level, and no tick is issued for that cycle.
REQ-021 SHALL make the first tick after en rises or clr falls occur DIV(level_cur) cycles later.
REQ-022 SHALL drive pend combinationally as (clamped level != level_cur).
REQ-023 SHALL, when level changes again before a wrap, apply only the value present at the wrap cycle.

Reset
REQ-024 SHALL, on reset low, asynchronously set cnt=0, level_cur=0, CLKHZ=0 and all optional state to 0.
REQ-025 SHALL, on reset release, make the first tick occur DIV(0) cycles after the first rising edge with en=1.
REQ-026 SHALL abort any period in progress when reset asserts, with no tick emitted.

Configuration
REQ-027 SHALL, with LEVEL_CLK_SQUARE_EN defined, add output CLK_SQ (1 bit, reset 0) that toggles on every tick, giving a 50% duty square wave of period 2*DIV; CLK_SQ SHALL hold its value when en=0 and clear to 0 on clr.
REQ-028 SHALL, without LEVEL_CLK_SQUARE_EN defined, omit the CLK_SQ port and its register entirely.

Verification (bench: BASE_DIV=16, NUM_LEVELS=4, giving divisors 16/8/4/2)
REQ-029 SHALL cover: reset release, en=1, level=0 -> CLKHZ pulses once every 16 cycles, first pulse 16 cycles after en; level_cur=0.
REQ-030 SHALL cover: level 0->2 at cnt=5 -> pend=1 for 11 cycles, next tick on schedule (cycle 16), then period 4; level_cur=2 after the wrap.
REQ-031 SHALL cover: level=3 -> period 2 (clamp floor); level=3 with NUM_LEVELS=3 build -> treated as 2, period 4, pend=0.
REQ-032 SHALL cover: clr pulse coinciding with cnt=DIV-1 -> no tick that period, next tick DIV cycles after clr falls; en=0 for 10 cycles -> CLKHZ stays 0, level_cur follows level immediately.
REQ-033 SHALL cover: reset asserted mid-period with level_cur=1 -> CLKHZ=0 and level_cur=0 immediately, with no clock edge required.
REQ-034 SHALL cover, with LEVEL_CLK_SQUARE_EN: level=1 -> CLK_SQ high 8 cycles and low 8 cycles; without the macro -> build has no CLK_SQ port.

Source files
------------

// File: rtl/level_clk_sel.sv
// level_clk_sel
// -------------------------------------------------------------------------
// Selectable-rate tick generator. Each speed level k divides the clock by
// DIV(k) = BASE_DIV >> k, with a floor of 2. The tick CLKHZ is a registered,
// one-cycle pulse. A new speed level takes effect only when the period
// counter wraps, so a running period is never cut short. When the generator
// is disabled or restarted, the level loads at once.
//
// Optional feature (macro LEVEL_CLK_SQUARE_EN):
//   Adds output CLK_SQ. It toggles on every tick and gives a 50% duty
//   square wave with a period of 2*DIV. It holds while en=0 and clears on
//   clr. Without the macro, neither the port nor its register exists.
//
// Parameters:
//   NUM_LEVELS  number of speed levels (2..16)
//   BASE_DIV    level-0 tick period in clock cycles
//   CNT_W       counter width; must hold BASE_DIV-1
//   LEVEL_W     derived: max(1, ceil(log2(NUM_LEVELS)))
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   en         in   tick generation enable
//   clr        in   synchronous period restart (priority over en)
//   level      in   requested speed level (clamped to NUM_LEVELS-1)
//   CLKHZ      out  registered one-cycle tick pulse
//   level_cur  out  level currently in force
//   pend       out  requested (clamped) level differs from level_cur
//   CLK_SQ     out  square wave (only with LEVEL_CLK_SQUARE_EN)
// -------------------------------------------------------------------------
module level_clk_sel #(
    parameter int NUM_LEVELS = 4,
    parameter int BASE_DIV   = 50000000,
    parameter int CNT_W      = 26,
    localparam int LEVEL_W   = (NUM_LEVELS <= 2) ? 1 : $clog2(NUM_LEVELS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [LEVEL_W-1:0] level,
    output logic               CLKHZ,
    output logic [LEVEL_W-1:0] level_cur,
    output logic               pend
`ifdef LEVEL_CLK_SQUARE_EN
    ,
    output logic               CLK_SQ
`endif
);

    logic [CNT_W-1:0]   r_cnt;
    logic [LEVEL_W-1:0] r_level_cur;
    logic               r_clkhz;
    logic [LEVEL_W-1:0] w_level_clamped;
    logic [CNT_W-1:0]   w_div_m1;
    logic               w_wrap;

    // Terminal count DIV(k)-1 for level k. The floor of 2 keeps every
    // period at least two cycles, so a tick is always a single-cycle pulse.
    function automatic logic [CNT_W-1:0] div_m1_of(input logic [LEVEL_W-1:0] k);
        logic [31:0] d;
        d = 32'(BASE_DIV) >> k;
        if (d < 32'd2) begin
            d = 32'd2;
        end
        return CNT_W'(d - 32'd1);
    endfunction

    // Clamp out-of-range requests before any use, including pend.
    always_comb begin
        w_level_clamped = level;
        if (level > LEVEL_W'(NUM_LEVELS - 1)) begin
            w_level_clamped = LEVEL_W'(NUM_LEVELS - 1);
        end
    end

    assign w_div_m1 = div_m1_of(r_level_cur);
    assign w_wrap   = en && !clr && (r_cnt == w_div_m1);

    // Precedence: clr, then en=0, then wrap, then count. level_cur changes
    // only at a wrap or while stopped or restarting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_level_cur <= '0;
            r_clkhz     <= 1'b0;
        end else if (clr || !en) begin
            r_cnt       <= '0;
            r_level_cur <= w_level_clamped;
            r_clkhz     <= 1'b0;
        end else if (w_wrap) begin
            r_cnt       <= '0;
            r_level_cur <= w_level_clamped;
            r_clkhz     <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
            r_clkhz     <= 1'b0;
        end
    end

    assign CLKHZ     = r_clkhz;
    assign level_cur = r_level_cur;
    assign pend      = (w_level_clamped != r_level_cur);

`ifdef LEVEL_CLK_SQUARE_EN
    logic r_sq;

    // Toggles on the same edge that raises CLKHZ. It holds while en=0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sq <= 1'b0;
        end else if (clr) begin
            r_sq <= 1'b0;
        end else if (w_wrap) begin
            r_sq <= ~r_sq;
        end
    end

    assign CLK_SQ = r_sq;
`endif

endmodule

// File: tb/tb_level_clk_sel.sv
module tb_level_clk_sel;

    logic       clock;
    logic       reset;
    logic       en;
    logic       clr;
    logic [1:0] level;
    logic       clkhz;
    logic [1:0] level_cur;
    logic       pend;
    logic       clkhz3;
    logic [1:0] level_cur3;
    logic       pend3;
`ifdef LEVEL_CLK_SQUARE_EN
    logic       clk_sq;
    logic       clk_sq3;
`endif

    int n_vec;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    level_clk_sel #(.NUM_LEVELS(4), .BASE_DIV(16), .CNT_W(5)) u_dut (
        .clock(clock), .reset(reset), .en(en), .clr(clr), .level(level),
        .CLKHZ(clkhz), .level_cur(level_cur), .pend(pend)
`ifdef LEVEL_CLK_SQUARE_EN
        , .CLK_SQ(clk_sq)
`endif
    );

    level_clk_sel #(.NUM_LEVELS(3), .BASE_DIV(16), .CNT_W(5)) u_dut3 (
        .clock(clock), .reset(reset), .en(en), .clr(clr), .level(level),
        .CLKHZ(clkhz3), .level_cur(level_cur3), .pend(pend3)
`ifdef LEVEL_CLK_SQUARE_EN
        , .CLK_SQ(clk_sq3)
`endif
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic       clr;
        logic [1:0] lvl;
        logic       exp_clk;
        logic [1:0] exp_lc;
        logic       exp_pend;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic e, input logic c, input logic [1:0] l,
                                input logic xc, input logic [1:0] xl, input logic xp);
        vec_t v;
        v.en = e; v.clr = c; v.lvl = l;
        v.exp_clk = xc; v.exp_lc = xl; v.exp_pend = xp;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Number of edges until CLKHZ is seen high; -1 if the bound expires.
    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!clkhz && n < max);
        if (!clkhz) n = -1;
    endtask

    task automatic wait_tick3(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!clkhz3 && n < max);
        if (!clkhz3) n = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [1:0] off_lvls[10];

        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        level  = 2'd0;

        // Reset state before any clock edge.
        #1;
        check("rst_clkhz", int'(clkhz), 0);
        check("rst_level_cur", int'(level_cur), 0);
        check("rst_pend", int'(pend), 0);
        step();
        step();
        reset = 1'b1;

        // Level 0: first tick 16 edges after en, then every 16.
        en = 1'b1;
        wait_tick(40, n);
        check("l0_first_tick", n, 16);
        wait_tick(40, n);
        check("l0_period", n, 16);
        check("l0_level_cur", int'(level_cur), 0);

        // Level 0 -> 2 at cnt=5: pend for 11 cycles, tick on schedule.
        for (int i = 0; i < 5; i++) step();
        level = 2'd2;
        #1;
        n = 0;
        while (pend && n < 40) begin
            n++;
            step();
        end
        check("chg_pend_cycles", n, 11);
        check("chg_tick_on_wrap", int'(clkhz), 1);
        check("chg_level_cur", int'(level_cur), 2);
        wait_tick(40, n);
        check("chg_new_period", n, 4);

        // Table-driven vectors: one edge per record.
        vecs[0]  = mk(0, 0, 3, 0, 3, 0);
        vecs[1]  = mk(1, 0, 3, 0, 3, 0);
        vecs[2]  = mk(1, 0, 3, 1, 3, 0);
        vecs[3]  = mk(1, 0, 3, 0, 3, 0);
        vecs[4]  = mk(1, 0, 3, 1, 3, 0);
        vecs[5]  = mk(1, 0, 2, 0, 3, 1);
        vecs[6]  = mk(1, 0, 2, 1, 2, 0);
        vecs[7]  = mk(1, 0, 2, 0, 2, 0);
        vecs[8]  = mk(1, 0, 2, 0, 2, 0);
        vecs[9]  = mk(1, 0, 2, 0, 2, 0);
        vecs[10] = mk(1, 0, 2, 1, 2, 0);
        vecs[11] = mk(0, 0, 1, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 1, 3, 0, 3, 0);
        vecs[14] = mk(1, 0, 3, 0, 3, 0);
        vecs[15] = mk(1, 1, 3, 0, 3, 0);
        vecs[16] = mk(1, 0, 3, 0, 3, 0);
        vecs[17] = mk(1, 0, 3, 1, 3, 0);
        vecs[18] = mk(1, 0, 2, 0, 3, 1);
        vecs[19] = mk(1, 0, 1, 1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            en    = vecs[i].en;
            clr   = vecs[i].clr;
            level = vecs[i].lvl;
            step();
            check($sformatf("vec%0d_clkhz", i), int'(clkhz), int'(vecs[i].exp_clk));
            check($sformatf("vec%0d_level_cur", i), int'(level_cur), int'(vecs[i].exp_lc));
            check($sformatf("vec%0d_pend", i), int'(pend), int'(vecs[i].exp_pend));
        end
        clr = 1'b0;

        // en=0 for 10 cycles: no ticks, level_cur follows level at once.
        off_lvls = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            level = off_lvls[i];
            step();
            check($sformatf("off%0d_clkhz", i), int'(clkhz), 0);
            check($sformatf("off%0d_level_cur", i), int'(level_cur), int'(off_lvls[i]));
        end

        // NUM_LEVELS=3 build: level 3 treated as 2, period 4, no pend.
        level = 2'd3;
        step();
        check("n3_level_cur", int'(level_cur3), 2);
        check("n3_pend", int'(pend3), 0);
        en = 1'b1;
        wait_tick3(40, n);
        check("n3_first_tick", n, 4);
        wait_tick3(40, n);
        check("n3_period", n, 4);

`ifdef LEVEL_CLK_SQUARE_EN
        // Level 1: square wave 8 high, 8 low.
        en = 1'b0;
        level = 2'd1;
        step();
        clr = 1'b1;
        step();
        check("sq_clr", int'(clk_sq), 0);
        clr = 1'b0;
        en = 1'b1;
        wait_tick(40, n);
        check("sq_first_tick", n, 8);
        check("sq_rise", int'(clk_sq), 1);
        n = 0;
        while (clk_sq && n < 40) begin
            n++;
            step();
        end
        check("sq_high_cycles", n, 8);
        n = 0;
        while (!clk_sq && n < 40) begin
            n++;
            step();
        end
        check("sq_low_cycles", n, 8);
`endif

        // Reset mid-period with level_cur=1: outputs clear with no edge.
        en = 1'b0;
        level = 2'd1;
        step();
        en = 1'b1;
        step();
        step();
        step();
        check("pre_rst_level_cur", int'(level_cur), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_clkhz", int'(clkhz), 0);
        check("async_rst_level_cur", int'(level_cur), 0);
        check("async_rst_pend", int'(pend), 1);
        step();
        reset = 1'b1;
        // First period after release runs at DIV(0), then level 1 loads.
        wait_tick(40, n);
        check("post_rst_first_tick", n, 16);
        check("post_rst_level_cur", int'(level_cur), 1);
        wait_tick(40, n);
        check("post_rst_period", n, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
